// File: rtl/demux_pkg.sv
// Shared constants and types for the 1:4 buffered distribution path.
package demux_pkg;

  localparam int unsigned DATA_W_DFLT = 128;
  localparam int unsigned CH_N        = 4;

  typedef logic [1:0] ch_sel_t;

endpackage

// File: rtl/chan_fifo.sv
// One output channel: small circular buffer with valid/ready head and delivered-word counter.
module chan_fifo #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  input  logic              pop_ready,
  output logic              valid,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     occ_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] last_q;
  logic [CNT_W-1:0]  count_q;
  logic              push_en, pop_en;

  assign full      = (occ_q == (PtrW+1)'(DEPTH));
  assign valid     = (occ_q != '0);
  assign push_en   = push & ~full;
  assign pop_en    = valid & pop_ready;
  // last_q keeps the most recent head visible once the channel drains
  assign head_data = valid ? mem_q[rd_ptr_q] : last_q;
  assign count     = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (valid) begin
        last_q <= mem_q[rd_ptr_q];
      end
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        occ_q    <= '0;
        count_q  <= '0;
      end else begin
        if (push_en) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
        if (pop_en) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
          count_q  <= count_q + 1'b1;
        end
        if (push_en && !pop_en) begin
          occ_q <= occ_q + 1'b1;
        end else if (!push_en && pop_en) begin
          occ_q <= occ_q - 1'b1;
        end
      end
    end
  end

  // Storage needs no reset: it is only observed while occupancy is non-zero.
  always_ff @(posedge clk) begin
    if (push_en && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/demux_1to4_buffered.sv
// Routes one valid/ready word stream to four buffered output channels by a 2-bit select.
module demux_1to4_buffered
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DFLT,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  ch_sel_t                in_sel,
  output logic [CH_N-1:0]        out_valid,
  input  logic [CH_N-1:0]        out_ready,
  output logic [CH_N*DATA_W-1:0] out_data,
  output logic [CH_N*CNT_W-1:0]  out_count
);

  logic [CH_N-1:0] full;
  logic [CH_N-1:0] push;
  logic            accept;

  // No pass-through: readiness depends only on the pre-edge fullness of the target.
  assign in_ready = rst_n & ~flush & ~full[in_sel];
  assign accept   = in_valid & in_ready;

  always_comb begin
    push = '0;
    if (accept) begin
      push[in_sel] = 1'b1;
    end
  end

  for (genvar k = 0; k < CH_N; k++) begin : g_chan
    chan_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .push      (push[k]),
      .push_data (in_data),
      .full      (full[k]),
      .pop_ready (out_ready[k]),
      .valid     (out_valid[k]),
      .head_data (out_data[k*DATA_W +: DATA_W]),
      .count     (out_count[k*CNT_W +: CNT_W])
    );
  end

endmodule
